// File: rtl/alu_issue.sv
// Purpose: decodes one MIPS ALU instruction, drives registered operands and ALUctr to an
//          external ALU, then captures the ALU result and the flags derived from it.
// Latency: out_valid rises two edges after acceptance; at most one instruction in flight
//          (three cycles minimum per instruction).
// Backpressure: in_ready drops from acceptance until out_ready retires the held result;
//          in_valid is ignored while busy.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         instruction handshake; instr, rs_data, rt_data are sampled on acceptance
//   alu_a, alu_b, alu_ctr     registered operands and control sent to the ALU
//   alu_result/zero/overflow  ALU response, sampled one edge after acceptance
//   out_valid/out_ready       result handshake
//   out_result, out_zero      captured result and zero flag
//   out_branch, out_trap      beq taken, signed-overflow trap (gated by TRAP_EN)
//   out_illegal               instruction could not be decoded
module alu_issue #(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_branch,
  output logic        out_trap,
  output logic        out_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state_q, state_d;

  // Instruction fields. Register indices are resolved by the register file upstream,
  // so rs/rt/rd numbers themselves are not needed here.
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_reg_idx;

  assign opcode         = instr[31:26];
  assign funct          = instr[5:0];
  assign shamt          = instr[10:6];
  assign imm            = instr[15:0];
  assign imm_sext       = {{16{imm[15]}}, imm};
  assign imm_zext       = {16'h0000, imm};
  assign unused_reg_idx = ^instr[25:16];

  // Decode results, registered on acceptance.
  logic [3:0]  dec_ctr;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_trap_cap;
  logic        dec_beq;
  logic        dec_illegal;

  // Per-instruction attributes carried from decode to result capture.
  logic        op_trap_cap;
  logic        op_beq;
  logic        op_illegal;

  logic        accept;
  logic        capture;

  always_comb begin
    dec_ctr      = 4'b0000;
    dec_a        = 32'h0;
    dec_b        = 32'h0;
    dec_trap_cap = 1'b0;
    dec_beq      = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: begin dec_ctr = 4'b1110; dec_a = rs_data; dec_b = rt_data; dec_trap_cap = 1'b1; end
          6'b100001: begin dec_ctr = 4'b0001; dec_a = rs_data; dec_b = rt_data; end
          6'b100010: begin dec_ctr = 4'b0100; dec_a = rs_data; dec_b = rt_data; dec_trap_cap = 1'b1; end
          6'b100011: begin dec_ctr = 4'b0101; dec_a = rs_data; dec_b = rt_data; end
          6'b100100: begin dec_ctr = 4'b0010; dec_a = rs_data; dec_b = rt_data; end
          6'b100101: begin dec_ctr = 4'b0011; dec_a = rs_data; dec_b = rt_data; end
          6'b100110: begin dec_ctr = 4'b0111; dec_a = rs_data; dec_b = rt_data; end
          6'b001000: begin dec_ctr = 4'b1100; dec_a = rs_data; dec_b = 32'h0; end
          // Shifts take the shift amount on A and the value to shift on B.
          6'b000000: begin dec_ctr = 4'b1010; dec_a = {27'h0, shamt}; dec_b = rt_data; end
          6'b000010: begin dec_ctr = 4'b1000; dec_a = {27'h0, shamt}; dec_b = rt_data; end
          6'b000011: begin dec_ctr = 4'b1001; dec_a = {27'h0, shamt}; dec_b = rt_data; end
          default:   dec_illegal = 1'b1;
        endcase
      end
      6'b001000: begin dec_ctr = 4'b1110; dec_a = rs_data; dec_b = imm_sext; dec_trap_cap = 1'b1; end
      6'b001001: begin dec_ctr = 4'b0001; dec_a = rs_data; dec_b = imm_sext; end
      6'b001100: begin dec_ctr = 4'b0010; dec_a = rs_data; dec_b = imm_zext; end
      6'b001101: begin dec_ctr = 4'b0011; dec_a = rs_data; dec_b = imm_zext; end
      6'b001110: begin dec_ctr = 4'b0111; dec_a = rs_data; dec_b = imm_zext; end
      6'b100011,
      6'b101011: begin dec_ctr = 4'b0001; dec_a = rs_data; dec_b = imm_sext; end
      6'b000100: begin dec_ctr = 4'b0101; dec_a = rs_data; dec_b = rt_data; dec_beq = 1'b1; end
      // lui is a left shift of the immediate by a constant 16.
      6'b001111: begin dec_ctr = 4'b0110; dec_a = 32'd16; dec_b = imm_zext; end
      default:   dec_illegal = 1'b1;
    endcase
  end

  assign accept  = (state_q == IDLE) && in_valid;
  assign capture = (state_q == EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gates in_ready directly so no instruction is offered while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= 32'h0;
      alu_b       <= 32'h0;
      alu_ctr     <= 4'b0000;
      op_trap_cap <= 1'b0;
      op_beq      <= 1'b0;
      op_illegal  <= 1'b0;
      out_result  <= 32'h0;
      out_zero    <= 1'b0;
      out_branch  <= 1'b0;
      out_trap    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a       <= dec_a;
        alu_b       <= dec_b;
        alu_ctr     <= dec_ctr;
        op_trap_cap <= dec_trap_cap;
        op_beq      <= dec_beq;
        op_illegal  <= dec_illegal;
      end
      if (capture) begin
        // An undecodable op reports a zero result and a clear Zero flag even though
        // the ALU sees 0 op 0 and would report Zero=1.
        out_result  <= op_illegal ? 32'h0 : alu_result;
        out_zero    <= op_illegal ? 1'b0 : alu_zero;
        out_branch  <= alu_zero && op_beq;
        out_trap    <= TRAP_EN && alu_overflow && op_trap_cap;
        out_illegal <= op_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (trap enabled / disabled) share stimulus, each drives
// its own copy of the team ALU behaviour, and outputs are compared to a reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;

  always #5 clk = ~clk;

  // Instance with TRAP_EN=1
  logic        in_ready, out_valid, out_zero, out_branch, out_trap, out_illegal;
  logic        alu_zero, alu_overflow;
  logic [31:0] alu_a, alu_b, alu_result, out_result;
  logic [3:0]  alu_ctr;
  // Instance with TRAP_EN=0
  logic        in_ready_n, out_valid_n, out_zero_n, out_branch_n, out_trap_n, out_illegal_n;
  logic        alu_zero_n, alu_overflow_n;
  logic [31:0] alu_a_n, alu_b_n, alu_result_n, out_result_n;
  logic [3:0]  alu_ctr_n;

  alu_issue #(.TRAP_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_branch(out_branch), .out_trap(out_trap), .out_illegal(out_illegal)
  );

  alu_issue #(.TRAP_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_a(alu_a_n), .alu_b(alu_b_n), .alu_ctr(alu_ctr_n),
    .alu_result(alu_result_n), .alu_zero(alu_zero_n), .alu_overflow(alu_overflow_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_result(out_result_n), .out_zero(out_zero_n),
    .out_branch(out_branch_n), .out_trap(out_trap_n), .out_illegal(out_illegal_n)
  );

  // Team ALU behaviour: {overflow, zero, result}.
  function automatic logic [33:0] team_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctr);
    logic [31:0] r;
    logic        v;
    r = 32'h0;
    v = 1'b0;
    case (ctr)
      4'b1110: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0001: r = a + b;
      4'b0100: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0101: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0111: r = a ^ b;
      4'b1100: r = a + b;
      4'b1010: r = b << a[4:0];
      4'b1000: r = b >> a[4:0];
      4'b1001: r = $signed(b) >>> a[4:0];
      4'b0110: r = b << a[4:0];
      default: r = 32'h0;
    endcase
    return {v, (r == 32'h0), r};
  endfunction

  assign {alu_overflow, alu_zero, alu_result}       = team_alu(alu_a, alu_b, alu_ctr);
  assign {alu_overflow_n, alu_zero_n, alu_result_n} = team_alu(alu_a_n, alu_b_n, alu_ctr_n);

  // Reference model: what an instruction must produce, from its architectural meaning.
  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] a, b, res;
    logic        zero, branch, trap, illegal;
  } exp_t;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] se, ze;
    longint      s;
    logic        cap;
    op = i[31:26]; fn = i[5:0]; sh = i[10:6];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    s = 0; cap = 1'b0;
    e.ctr = 4'b0; e.a = rs; e.b = rt; e.res = 32'h0;
    e.zero = 1'b0; e.branch = 1'b0; e.trap = 1'b0; e.illegal = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin e.ctr = 4'b1110; e.res = rs + rt; cap = 1'b1;
                     s = longint'($signed(rs)) + longint'($signed(rt)); end
        6'h21: begin e.ctr = 4'b0001; e.res = rs + rt; end
        6'h22: begin e.ctr = 4'b0100; e.res = rs - rt; cap = 1'b1;
                     s = longint'($signed(rs)) - longint'($signed(rt)); end
        6'h23: begin e.ctr = 4'b0101; e.res = rs - rt; end
        6'h24: begin e.ctr = 4'b0010; e.res = rs & rt; end
        6'h25: begin e.ctr = 4'b0011; e.res = rs | rt; end
        6'h26: begin e.ctr = 4'b0111; e.res = rs ^ rt; end
        6'h08: begin e.ctr = 4'b1100; e.b = 32'h0; e.res = rs; end
        6'h00: begin e.ctr = 4'b1010; e.a = {27'h0, sh}; e.res = rt << sh; end
        6'h02: begin e.ctr = 4'b1000; e.a = {27'h0, sh}; e.res = rt >> sh; end
        6'h03: begin e.ctr = 4'b1001; e.a = {27'h0, sh}; e.res = $signed(rt) >>> sh; end
        default: e.illegal = 1'b1;
      endcase
      6'h08: begin e.ctr = 4'b1110; e.b = se; e.res = rs + se; cap = 1'b1;
                   s = longint'($signed(rs)) + longint'($signed(se)); end
      6'h09: begin e.ctr = 4'b0001; e.b = se; e.res = rs + se; end
      6'h0C: begin e.ctr = 4'b0010; e.b = ze; e.res = rs & ze; end
      6'h0D: begin e.ctr = 4'b0011; e.b = ze; e.res = rs | ze; end
      6'h0E: begin e.ctr = 4'b0111; e.b = ze; e.res = rs ^ ze; end
      6'h23, 6'h2B: begin e.ctr = 4'b0001; e.b = se; e.res = rs + se; end
      6'h04: begin e.ctr = 4'b0101; e.res = rs - rt; end
      6'h0F: begin e.ctr = 4'b0110; e.a = 32'd16; e.b = ze; e.res = {i[15:0], 16'h0}; end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.ctr = 4'b0; e.a = 32'h0; e.b = 32'h0; e.res = 32'h0;
    end else begin
      e.zero = (e.res == 32'h0);
    end
    // Overflow: the exact 64-bit sum differs from the 32-bit result read as signed.
    e.trap   = cap && (s != longint'($signed(e.res)));
    e.branch = (op == 6'h04) && e.zero;
    return e;
  endfunction

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction tracker: 0 waiting, 1 executing, 2 result held.
  int   phase = 0;
  bit   clean = 1'b1;
  exp_t cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0;
      clean = 1'b1;
    end else begin
      case (phase)
        0: if (in_valid) begin phase = 1; clean = 1'b0; cur = model(instr, rs_data, rt_data); end
        1: phase = 2;
        default: if (out_ready) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", {95'h0, in_ready}, {95'h0, (phase == 0) && !rst});
    check("out_valid", {94'h0, out_valid, out_valid_n}, {94'h0, phase == 2, phase == 2});
    if (clean)
      check("reset_zero", {alu_a, alu_b, alu_ctr, out_result, out_zero, out_branch, out_trap, out_illegal},
            96'h0);
    if (phase >= 1)
      check("alu_drive", {28'h0, alu_ctr, alu_a, alu_b}, {28'h0, cur.ctr, cur.a, cur.b});
    if (phase == 2) begin
      check("result", {60'h0, out_result, out_zero, out_branch, out_trap, out_illegal},
            {60'h0, cur.res, cur.zero, cur.branch, cur.trap, cur.illegal});
      check("result_notrap", {62'h0, out_result_n, out_trap_n, out_illegal_n},
            {62'h0, cur.res, 1'b0, cur.illegal});
    end
  end

  // Values captured by issue() for literal checks.
  logic [31:0] cap_a, cap_b, cap_res;
  logic [3:0]  cap_ctr;
  logic        cap_zero, cap_branch, cap_trap, cap_trap_n, cap_ill;
  int          cap_lat;

  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input int stall);
    int n;
    @(negedge clk);
    instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("accept_timeout", {95'h0, in_ready}, 96'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    cap_a = alu_a; cap_b = alu_b; cap_ctr = alu_ctr;
    cap_lat = 1;
    while (!out_valid && cap_lat < 10) begin @(posedge clk); cap_lat++; @(negedge clk); end
    if (!out_valid) check("done_timeout", {95'h0, out_valid}, 96'h1);
    cap_res = out_result; cap_zero = out_zero; cap_branch = out_branch;
    cap_trap = out_trap; cap_trap_n = out_trap_n; cap_ill = out_illegal;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_hold", {62'h0, out_result, out_valid, in_ready}, {62'h0, cap_res, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam int NV = 18;
  logic [31:0] tv_i[NV] = '{32'h00221822, 32'h00221823, 32'h00221824, 32'h00221825, 32'h00221826,
                            32'h00200008, 32'h00021902, 32'h00021903, 32'h2421FFFF, 32'h3021FFFF,
                            32'h34218000, 32'h3821FFFF, 32'h8C21FFFC, 32'hAC210008, 32'h10220004,
                            32'h00221820, 32'h00221827, 32'h00221821};
  logic [31:0] tv_s[NV] = '{32'h80000000, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                            32'h00400100, 32'h0, 32'h0, 32'h5, 32'h12345678,
                            32'h12340000, 32'hFFFF0000, 32'h1000, 32'h1000, 32'h1,
                            32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF};
  logic [31:0] tv_t[NV] = '{32'h1, 32'h7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F,
                            32'h12345678, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'h0, 32'h0, 32'h2,
                            32'h1, 32'h2, 32'h1};
  logic [31:0] tv_r[NV] = '{32'h7FFFFFFF, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F,
                            32'h00400100, 32'h08000000, 32'hF8000000, 32'h4, 32'h5678,
                            32'h12348000, 32'hFFFFFFFF, 32'hFFC, 32'h1008, 32'hFFFFFFFF,
                            32'h80000000, 32'h0, 32'h80000000};
  logic        tv_trap[NV] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {95'h0, in_ready}, 96'h1);

    // add, with latency and a 5-cycle consumer stall
    issue(32'h00221820, 32'h34, 32'h12, 5);
    check("add_ctr", {92'h0, cap_ctr}, {92'h0, 4'b1110});
    check("add_res", {64'h0, cap_res}, {64'h0, 32'h46});
    check("add_trap", {95'h0, cap_trap}, 96'h0);
    check("add_latency", 96'(cap_lat), 96'd2);

    issue(32'h000218C0, 32'h0, 32'hFFFFFFFF, 0);
    check("sll_ops", {28'h0, cap_ctr, cap_a, cap_b}, {28'h0, 4'b1010, 32'h3, 32'hFFFFFFFF});
    check("sll_res", {64'h0, cap_res}, {64'h0, 32'hFFFFFFF8});

    issue(32'h10220004, 32'h34, 32'h34, 1);
    check("beq_ctr", {92'h0, cap_ctr}, {92'h0, 4'b0101});
    check("beq_flags", {61'h0, cap_res, cap_zero, cap_branch}, {61'h0, 32'h0, 1'b1, 1'b1});

    issue(32'h20210001, 32'h7FFFFFFF, 32'h0, 0);
    check("addi_b", {64'h0, cap_b}, {64'h0, 32'h1});
    check("addi_trap", {94'h0, cap_trap, cap_trap_n}, {94'h0, 1'b1, 1'b0});
    check("addi_res", {64'h0, cap_res}, {64'h0, 32'h80000000});

    issue(32'h3C01AAAA, 32'h0, 32'h0, 0);
    check("lui_ops", {28'h0, cap_ctr, cap_a, cap_b}, {28'h0, 4'b0110, 32'd16, 32'h0000AAAA});
    check("lui_res", {64'h0, cap_res}, {64'h0, 32'hAAAA0000});

    issue(32'hFC000000, 32'h1234, 32'h5678, 0);
    check("illegal", {62'h0, cap_res, cap_ill, cap_zero}, {62'h0, 32'h0, 1'b1, 1'b0});

    for (int v = 0; v < NV; v++) begin
      issue(tv_i[v], tv_s[v], tv_t[v], v % 3);
      check($sformatf("vec%0d_res", v), {64'h0, cap_res}, {64'h0, tv_r[v]});
      check($sformatf("vec%0d_trap", v), {95'h0, cap_trap}, {95'h0, tv_trap[v]});
    end

    // Reset during EXEC discards the instruction.
    @(negedge clk);
    instr = 32'h00221820; rs_data = 32'h1; rt_data = 32'h2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {alu_a, alu_b, alu_ctr, out_result, out_valid, out_zero, out_trap, in_ready},
          96'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_release", {94'h0, in_ready, out_valid}, {94'h0, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_valid", {95'h0, out_valid}, 96'h0);
    end

    // Normal traffic after the aborted instruction.
    issue(32'h00221822, 32'h10, 32'h3, 0);
    check("post_rst_res", {64'h0, cap_res}, {64'h0, 32'hD});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter TRAP_EN, default 1: when 1, signed overflow on add/sub/addi sets out_trap; when 0, out_trap is never set.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction and operands are presented.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 rs_data, rt_data  input  32 each  register-file operands for rs and rt.
REQ-008 alu_a, alu_b  output  32 each  registered operands driven to the ALU A and B ports.
REQ-009 alu_ctr  output  4  registered ALUctr driven to the ALU.
REQ-010 alu_result  input  32  ALU Result; alu_zero input 1, ALU Zero; alu_overflow input 1, ALU Overflow.
REQ-011 out_valid  output  1  a completed result is held on the out_* ports.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  32  captured ALU result.
REQ-014 out_zero, out_branch, out_trap, out_illegal  output  1 each  Zero flag, beq taken, overflow trap, undecodable instruction.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on an edge with in_valid=1, the block SHALL decode instr, register alu_a/alu_b/alu_ctr and move to EXEC; otherwise it stays in IDLE.
REQ-018 EXEC: at the next edge, the block SHALL capture alu_result, alu_zero and the derived flags into the out_* registers and move to DONE.
REQ-019 DONE: the out_* registers SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
- Minimum spacing is 3 cycles per instruction.
- in_valid is ignored outside IDLE.
REQ-020 Latency: out_valid SHALL rise two edges after acceptance.
REQ-021 R-type (opcode 000000) decode by funct; A=rs_data, B=rt_data unless stated:
- add 100000->1110 (trap-capable)
- addu 100001->0001
- sub 100010->0100 (trap-capable)
- subu 100011->0101
- and 100100->0010
- or 100101->0011
- xor 100110->0111
- jr 001000->1100, B=0
REQ-022 Shifts: sll 000000->1010, srl 000010->1000, sra 000011->1001; A={27'b0,shamt}, B=rt_data.
REQ-023 I-type, A=rs_data:
- addi 001000->1110, B=sign-extended imm (trap-capable)
- addiu 001001->0001, B=sign-extended imm
- andi 001100->0010, B=zero-extended imm
- ori 001101->0011, B=zero-extended imm
- xori 001110->0111, B=zero-extended imm
- lw 100011 and sw 101011->0001, B=sign-extended imm
- beq 000100->0101, B=rt_data
REQ-024 lui 001111->0110 with A=32'd16 and B=zero-extended imm.
REQ-025 Any other opcode/funct SHALL give alu_ctr=0000, alu_a=alu_b=0, out_result=0, out_zero=0, out_illegal=1, with the full handshake still completed.
REQ-026 out_trap SHALL equal TRAP_EN & alu_overflow & trap-capable op; out_result SHALL still carry alu_result when out_trap is set.
REQ-027 out_branch SHALL equal alu_zero & (op==beq); out_zero SHALL equal alu_zero for all legal ops.

Reset
REQ-028 On rst, asynchronously: FSM to IDLE; alu_a, alu_b, alu_ctr and all out_* outputs to 0; out_valid=0; in_ready=0 while rst is held.
REQ-029 Reset asserted in EXEC or DONE SHALL discard the instruction, with no out_valid pulse after release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (bench connects the team ALU behind alu_a/alu_b/alu_ctr)
REQ-031 add: instr=0x00221820, rs=0x34, rt=0x12 -> alu_ctr=1110; out_result=0x46, trap=0, out_valid two edges after acceptance.
REQ-032 sll: instr=0x000218C0, rt=0xFFFFFFFF -> alu_a=3, alu_b=0xFFFFFFFF, alu_ctr=1010; out_result=0xFFFFFFF8.
REQ-033 beq: instr=0x10220004, rs=rt=0x34 -> alu_ctr=0101; out_zero=1, out_branch=1, out_result=0.
REQ-034 addi overflow: instr=0x20210001, rs=0x7FFFFFFF -> alu_b=1; out_trap=1 (TRAP_EN=1), out_trap=0 (TRAP_EN=0).
REQ-035 lui and illegal:
- instr=0x3C01AAAA -> alu_a=16, alu_b=0x0000AAAA, alu_ctr=0110.
- instr=0xFC000000 -> out_illegal=1, out_result=0.
REQ-036 Handshake and reset:
- out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- rst pulsed during EXEC -> all outputs 0, no out_valid, in_ready=1 on the cycle after release.
